// File: rtl/l1d_mshr_entry_pkg.sv
// Shared L1D MSHR types: allocation record, downstream request payloads and entry FSM encoding.
package l1d_mshr_entry_pkg;

  localparam int unsigned L1D_MSHR_NUM      = 8;
  localparam int unsigned L1D_MSHR_ID_WIDTH = $clog2(L1D_MSHR_NUM);
  localparam int unsigned L1D_INDEX_WIDTH   = 6;
  localparam int unsigned L1D_TAG_WIDTH     = 20;
  localparam int unsigned L1D_OFFSET_WIDTH  = 6;
  localparam int unsigned L1D_WAY_NUM       = 4;
  localparam int unsigned L1D_DATA_WIDTH    = 64;
  localparam int unsigned L1D_BYTE_EN_WIDTH = L1D_DATA_WIDTH / 8;
  localparam int unsigned L1D_SB_PLD_WIDTH  = 8;

  typedef logic [L1D_MSHR_ID_WIDTH-1:0] l1d_mshr_id_t;

  // Request fields the entry keeps for the whole transaction.
  typedef struct packed {
    logic [L1D_INDEX_WIDTH-1:0]   index;
    logic [L1D_TAG_WIDTH-1:0]     new_tag;
    logic [L1D_TAG_WIDTH-1:0]     evict_tag;
    logic [L1D_OFFSET_WIDTH-1:0]  offset;
    logic                         need_rw;
    logic [L1D_DATA_WIDTH-1:0]    wr_data;
    logic [L1D_BYTE_EN_WIDTH-1:0] wr_data_byte_en;
    logic [L1D_SB_PLD_WIDTH-1:0]  wr_sb_pld;
    logic                         need_evict;
    logic                         need_linefill;
    logic [L1D_WAY_NUM-1:0]       way;
    l1d_mshr_id_t                 mshr_id;
  } pack_l1d_mshr_req;

  typedef struct packed {
    pack_l1d_mshr_req req;
    l1d_mshr_id_t     mshr_hzd_index_way_line;
    l1d_mshr_id_t     mshr_hzd_evict_tag_line;
  } pack_l1d_mshr_state;

  typedef struct packed {
    logic [L1D_INDEX_WIDTH-1:0] index;
    logic [L1D_WAY_NUM-1:0]     way;
    logic [L1D_TAG_WIDTH-1:0]   evict_tag;
  } pack_l1d_evict_req;

  typedef struct packed {
    logic [L1D_TAG_WIDTH-1:0]   new_tag;
    logic [L1D_INDEX_WIDTH-1:0] index;
    logic [L1D_WAY_NUM-1:0]     way;
    l1d_mshr_id_t               mshr_id;
  } pack_l1d_linefill_req;

  typedef struct packed {
    logic [L1D_INDEX_WIDTH-1:0]   index;
    logic [L1D_WAY_NUM-1:0]       way;
    logic [L1D_OFFSET_WIDTH-1:0]  offset;
    logic                         is_read;
    logic [L1D_DATA_WIDTH-1:0]    wr_data;
    logic [L1D_BYTE_EN_WIDTH-1:0] byte_en;
    logic [L1D_SB_PLD_WIDTH-1:0]  sb_pld;
    l1d_mshr_id_t                 mshr_id;
  } pack_l1d_rw_req;

  typedef enum logic [2:0] {
    MSHR_IDLE,
    MSHR_WAIT_HZD,
    MSHR_EVICT_REQ,
    MSHR_EVICT_WAIT,
    MSHR_LF_REQ,
    MSHR_LF_WAIT,
    MSHR_RW_REQ,
    MSHR_RELEASE
  } l1d_mshr_fsm_e;

  // First request state once all hazards are gone.
  function automatic l1d_mshr_fsm_e mshr_dispatch(input logic need_evict, input logic need_linefill);
    if (need_evict)         return MSHR_EVICT_REQ;
    else if (need_linefill) return MSHR_LF_REQ;
    else                    return MSHR_RW_REQ;
  endfunction

endpackage

// File: rtl/l1d_mshr_hzd_tracker.sv
// Holds the index/way and evict-tag dependencies of one MSHR entry and clears them on matching releases.
module l1d_mshr_hzd_tracker
  import l1d_mshr_entry_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture_i,
  input  logic         iw_vld_i,
  input  l1d_mshr_id_t iw_id_i,
  input  logic         et_vld_i,
  input  l1d_mshr_id_t et_id_i,
  input  logic         rel_vld_i,
  input  l1d_mshr_id_t rel_id_i,
  output logic         hzd_pending_c_o
);

  logic         iw_vld_q, iw_vld_d;
  logic         et_vld_q, et_vld_d;
  l1d_mshr_id_t iw_id_q, iw_id_d;
  l1d_mshr_id_t et_id_q, et_id_d;

  // A release in the capture cycle already counts against the freshly captured ids.
  always_comb begin
    iw_vld_d = iw_vld_q;
    et_vld_d = et_vld_q;
    iw_id_d  = iw_id_q;
    et_id_d  = et_id_q;
    if (capture_i) begin
      iw_vld_d = iw_vld_i;
      et_vld_d = et_vld_i;
      iw_id_d  = iw_id_i;
      et_id_d  = et_id_i;
    end
    if (rel_vld_i && (rel_id_i == iw_id_d)) iw_vld_d = 1'b0;
    if (rel_vld_i && (rel_id_i == et_id_d)) et_vld_d = 1'b0;
    hzd_pending_c_o = iw_vld_d | et_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iw_vld_q <= 1'b0;
      et_vld_q <= 1'b0;
      iw_id_q  <= '0;
      et_id_q  <= '0;
    end else begin
      iw_vld_q <= iw_vld_d;
      et_vld_q <= et_vld_d;
      iw_id_q  <= iw_id_d;
      et_id_q  <= et_id_d;
    end
  end

endmodule

// File: rtl/l1d_mshr_entry.sv
// One L1D MSHR entry: waits out hazards, then issues evict, linefill and data-array RW in order and releases.
// Optional watchdog enabled with L1D_MSHR_TIMEOUT_EN.
module l1d_mshr_entry
  import l1d_mshr_entry_pkg::*;
#(
  parameter int unsigned ENTRY_ID       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_vld,
  input  pack_l1d_mshr_state   alloc_pld,
  input  logic                 alloc_hzd_iw_vld,
  input  logic                 alloc_hzd_et_vld,
  input  logic                 rel_bcast_vld,
  input  l1d_mshr_id_t         rel_bcast_id,
  output logic                 entry_busy,
  output logic                 evict_req_vld,
  input  logic                 evict_req_rdy,
  output pack_l1d_evict_req    evict_req_pld,
  input  logic                 evict_done,
  output logic                 linefill_req_vld,
  input  logic                 linefill_req_rdy,
  output pack_l1d_linefill_req linefill_req_pld,
  input  logic                 linefill_done,
  output logic                 rw_req_vld,
  input  logic                 rw_req_rdy,
  output pack_l1d_rw_req       rw_req_pld,
  output logic                 rel_vld,
  output l1d_mshr_id_t         rel_id,
  output logic                 timeout_err
);

  if (ENTRY_ID >= L1D_MSHR_NUM) begin : g_bad_entry_id
    $error("l1d_mshr_entry: ENTRY_ID out of range");
  end
  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("l1d_mshr_entry: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  l1d_mshr_fsm_e    state_q, state_d;
  pack_l1d_mshr_req pld_q, pld_d;
  logic             alloc_take;
  logic             hzd_pending_c;

  l1d_mshr_hzd_tracker u_hzd_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .capture_i       (alloc_take),
    .iw_vld_i        (alloc_hzd_iw_vld),
    .iw_id_i         (alloc_pld.mshr_hzd_index_way_line),
    .et_vld_i        (alloc_hzd_et_vld),
    .et_id_i         (alloc_pld.mshr_hzd_evict_tag_line),
    .rel_vld_i       (rel_bcast_vld),
    .rel_id_i        (rel_bcast_id),
    .hzd_pending_c_o (hzd_pending_c)
  );

  always_comb begin
    state_d    = state_q;
    pld_d      = pld_q;
    alloc_take = 1'b0;
    case (state_q)
      MSHR_IDLE: begin
        if (alloc_vld) begin
          alloc_take = 1'b1;
          pld_d      = alloc_pld.req;
          state_d    = hzd_pending_c ? MSHR_WAIT_HZD
                     : mshr_dispatch(alloc_pld.req.need_evict, alloc_pld.req.need_linefill);
        end
      end
      MSHR_WAIT_HZD:   if (!hzd_pending_c) state_d = mshr_dispatch(pld_q.need_evict, pld_q.need_linefill);
      MSHR_EVICT_REQ:  if (evict_req_rdy) state_d = MSHR_EVICT_WAIT;
      MSHR_EVICT_WAIT: if (evict_done) state_d = MSHR_LF_REQ;
      MSHR_LF_REQ:     if (linefill_req_rdy) state_d = MSHR_LF_WAIT;
      MSHR_LF_WAIT:    if (linefill_done) state_d = MSHR_RW_REQ;
      MSHR_RW_REQ:     if (rw_req_rdy) state_d = MSHR_RELEASE;
      MSHR_RELEASE:    state_d = MSHR_IDLE;
      default:         state_d = MSHR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MSHR_IDLE;
      pld_q   <= '0;
    end else begin
      state_q <= state_d;
      pld_q   <= pld_d;
    end
  end

  // Request payloads come straight from the captured record, so they hold steady while vld waits for rdy.
  always_comb begin
    evict_req_pld           = '0;
    evict_req_pld.index     = pld_q.index;
    evict_req_pld.way       = pld_q.way;
    evict_req_pld.evict_tag = pld_q.evict_tag;

    linefill_req_pld         = '0;
    linefill_req_pld.new_tag = pld_q.new_tag;
    linefill_req_pld.index   = pld_q.index;
    linefill_req_pld.way     = pld_q.way;
    linefill_req_pld.mshr_id = pld_q.mshr_id;

    rw_req_pld         = '0;
    rw_req_pld.index   = pld_q.index;
    rw_req_pld.way     = pld_q.way;
    rw_req_pld.offset  = pld_q.offset;
    rw_req_pld.is_read = pld_q.need_rw;
    rw_req_pld.wr_data = pld_q.wr_data;
    rw_req_pld.byte_en = pld_q.wr_data_byte_en;
    rw_req_pld.sb_pld  = pld_q.wr_sb_pld;
    rw_req_pld.mshr_id = pld_q.mshr_id;
  end

  assign entry_busy       = (state_q != MSHR_IDLE);
  assign evict_req_vld    = (state_q == MSHR_EVICT_REQ);
  assign linefill_req_vld = (state_q == MSHR_LF_REQ);
  assign rw_req_vld       = (state_q == MSHR_RW_REQ);
  assign rel_vld          = (state_q == MSHR_RELEASE);
  assign rel_id           = L1D_MSHR_ID_WIDTH'(ENTRY_ID);

`ifdef L1D_MSHR_TIMEOUT_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  // Counts consecutive cycles spent waiting on something outside the entry; any state change restarts it.
  always_comb begin
    wdog_cnt_d    = wdog_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_d != state_q) begin
      wdog_cnt_d = '0;
    end else if ((state_q inside {MSHR_WAIT_HZD, MSHR_EVICT_WAIT, MSHR_LF_WAIT}) &&
                 (wdog_cnt_q != 16'hFFFF)) begin
      wdog_cnt_d = wdog_cnt_q + 16'd1;
    end
    if (wdog_cnt_d == 16'(TIMEOUT_CYCLES)) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_cnt_q    <= wdog_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_l1d_mshr_entry.sv
// Randomized bench for l1d_mshr_entry against a step-list reference model of one MSHR transaction.
module tb_l1d_mshr_entry;
  import l1d_mshr_entry_pkg::*;

  localparam int unsigned TB_ID = 6;

  typedef enum int {ST_EV_REQ, ST_EV_DONE, ST_LF_REQ, ST_LF_DONE, ST_RW_REQ, ST_REL} step_e;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alloc_vld;
  pack_l1d_mshr_state   alloc_pld;
  logic                 alloc_hzd_iw_vld, alloc_hzd_et_vld;
  logic                 rel_bcast_vld;
  l1d_mshr_id_t         rel_bcast_id;
  logic                 entry_busy;
  logic                 evict_req_vld, evict_req_rdy, evict_done;
  pack_l1d_evict_req    evict_req_pld;
  logic                 linefill_req_vld, linefill_req_rdy, linefill_done;
  pack_l1d_linefill_req linefill_req_pld;
  logic                 rw_req_vld, rw_req_rdy;
  pack_l1d_rw_req       rw_req_pld;
  logic                 rel_vld;
  l1d_mshr_id_t         rel_id;
  logic                 timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l1d_mshr_entry #(.ENTRY_ID(TB_ID), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_vld(alloc_vld), .alloc_pld(alloc_pld),
    .alloc_hzd_iw_vld(alloc_hzd_iw_vld), .alloc_hzd_et_vld(alloc_hzd_et_vld),
    .rel_bcast_vld(rel_bcast_vld), .rel_bcast_id(rel_bcast_id),
    .entry_busy(entry_busy),
    .evict_req_vld(evict_req_vld), .evict_req_rdy(evict_req_rdy), .evict_req_pld(evict_req_pld),
    .evict_done(evict_done),
    .linefill_req_vld(linefill_req_vld), .linefill_req_rdy(linefill_req_rdy),
    .linefill_req_pld(linefill_req_pld), .linefill_done(linefill_done),
    .rw_req_vld(rw_req_vld), .rw_req_rdy(rw_req_rdy), .rw_req_pld(rw_req_pld),
    .rel_vld(rel_vld), .rel_id(rel_id), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic l1d_mshr_id_t rand_peer();
    int v;
    v = int'($urandom_range(0, L1D_MSHR_NUM - 2));
    if (v >= int'(TB_ID)) v++;
    return L1D_MSHR_ID_WIDTH'(v);
  endfunction

  function automatic pack_l1d_mshr_req rand_req();
    pack_l1d_mshr_req r;
    r.index           = L1D_INDEX_WIDTH'($urandom);
    r.new_tag         = L1D_TAG_WIDTH'($urandom);
    r.evict_tag       = L1D_TAG_WIDTH'($urandom);
    r.offset          = L1D_OFFSET_WIDTH'($urandom);
    r.need_rw         = 1'($urandom);
    r.wr_data         = {$urandom, $urandom};
    r.wr_data_byte_en = L1D_BYTE_EN_WIDTH'($urandom);
    r.wr_sb_pld       = L1D_SB_PLD_WIDTH'($urandom);
    r.need_evict      = 1'($urandom);
    r.need_linefill   = r.need_evict | 1'($urandom);
    r.way             = L1D_WAY_NUM'(1 << $urandom_range(0, L1D_WAY_NUM - 1));
    r.mshr_id         = L1D_MSHR_ID_WIDTH'(TB_ID);
    return r;
  endfunction

  task automatic idle_inputs();
    alloc_vld = 1'b0; alloc_pld = '0;
    alloc_hzd_iw_vld = 1'b0; alloc_hzd_et_vld = 1'b0;
    rel_bcast_vld = 1'b0; rel_bcast_id = '0;
    evict_req_rdy = 1'b0; linefill_req_rdy = 1'b0; rw_req_rdy = 1'b0;
    evict_done = 1'b0; linefill_done = 1'b0;
  endtask

  // One transaction, entered and left on a negedge with the entry idle.
  // bmode: 0 random broadcasts, 1 scripted (id 2 for 10 cycles, then id 3). rmode: 0 ready, 1 random, 2 stall 5.
  task automatic run_txn(input pack_l1d_mshr_req r,
                         input logic iw_v, input l1d_mshr_id_t iw_id,
                         input logic et_v, input l1d_mshr_id_t et_id,
                         input logic abc_v, input l1d_mshr_id_t abc_id,
                         input int bmode, input int rmode);
    step_e                steps[$];
    l1d_mshr_id_t         pend[$];
    pack_l1d_evict_req    exp_ev;
    pack_l1d_linefill_req exp_lf;
    pack_l1d_rw_req       exp_rw;
    int                   cyc, stall;
    logic                 rdy;
    step_e                hd;

    if (r.need_evict) begin steps.push_back(ST_EV_REQ); steps.push_back(ST_EV_DONE); end
    if (r.need_linefill) begin steps.push_back(ST_LF_REQ); steps.push_back(ST_LF_DONE); end
    steps.push_back(ST_RW_REQ);
    steps.push_back(ST_REL);
    if (iw_v && !(abc_v && abc_id == iw_id)) pend.push_back(iw_id);
    if (et_v && !(abc_v && abc_id == et_id)) pend.push_back(et_id);

    exp_ev = '{index: r.index, way: r.way, evict_tag: r.evict_tag};
    exp_lf = '{new_tag: r.new_tag, index: r.index, way: r.way, mshr_id: r.mshr_id};
    exp_rw = '{index: r.index, way: r.way, offset: r.offset, is_read: r.need_rw, wr_data: r.wr_data,
               byte_en: r.wr_data_byte_en, sb_pld: r.wr_sb_pld, mshr_id: r.mshr_id};

    alloc_vld = 1'b1;
    alloc_pld = '{req: r, mshr_hzd_index_way_line: iw_id, mshr_hzd_evict_tag_line: et_id};
    alloc_hzd_iw_vld = iw_v; alloc_hzd_et_vld = et_v;
    rel_bcast_vld = abc_v; rel_bcast_id = abc_id;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();

    cyc = 0; stall = 0;
    while (steps.size() > 0 && cyc < 400) begin
      hd = (pend.size() == 0) ? steps[0] : ST_EV_DONE;
      check("busy", 128'(entry_busy), 128'(1'b1));
      check("evict_vld", 128'(evict_req_vld), 128'(pend.size() == 0 && hd == ST_EV_REQ));
      check("lf_vld", 128'(linefill_req_vld), 128'(pend.size() == 0 && hd == ST_LF_REQ));
      check("rw_vld", 128'(rw_req_vld), 128'(pend.size() == 0 && hd == ST_RW_REQ));
      check("rel_vld", 128'(rel_vld), 128'(pend.size() == 0 && hd == ST_REL));
      if (pend.size() == 0) begin
        if (hd == ST_EV_REQ) check("evict_pld", 128'(evict_req_pld), 128'(exp_ev));
        if (hd == ST_LF_REQ) check("lf_pld", 128'(linefill_req_pld), 128'(exp_lf));
        if (hd == ST_RW_REQ) check("rw_pld", 128'(rw_req_pld), 128'(exp_rw));
        if (hd == ST_REL) check("rel_id", 128'(rel_id), 128'(TB_ID));
      end
`ifndef L1D_MSHR_TIMEOUT_EN
      check("timeout_err", 128'(timeout_err), 128'(1'b0));
`endif
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : (stall >= 5);
      evict_req_rdy = rdy;
      linefill_req_rdy = (rmode == 1) ? 1'($urandom) : rdy;
      rw_req_rdy = (rmode == 1) ? 1'($urandom) : rdy;
      evict_done = (rmode == 1) ? 1'($urandom) : 1'b1;
      linefill_done = (rmode == 1) ? 1'($urandom) : 1'b1;
      if (pend.size() > 0 && bmode == 1) begin
        rel_bcast_vld = 1'b1;
        rel_bcast_id = (cyc >= 10) ? L1D_MSHR_ID_WIDTH'(3) : L1D_MSHR_ID_WIDTH'(2);
      end else begin
        rel_bcast_vld = ($urandom_range(0, 2) == 0);
        rel_bcast_id = rand_peer();
      end
      @(posedge clk);
      if (pend.size() > 0) begin
        if (rel_bcast_vld)
          for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i] == rel_bcast_id) pend.delete(i);
      end else begin
        case (steps[0])
          ST_EV_REQ:  if (evict_req_rdy) void'(steps.pop_front()); else stall++;
          ST_EV_DONE: if (evict_done) void'(steps.pop_front());
          ST_LF_REQ:  if (linefill_req_rdy) void'(steps.pop_front()); else stall++;
          ST_LF_DONE: if (linefill_done) void'(steps.pop_front());
          ST_RW_REQ:  if (rw_req_rdy) void'(steps.pop_front()); else stall++;
          default:    void'(steps.pop_front());
        endcase
        if (steps.size() > 0 && steps[0] inside {ST_EV_DONE, ST_LF_DONE, ST_REL}) stall = 0;
      end
      @(negedge clk);
      idle_inputs();
      cyc++;
    end
    check("txn_complete", 128'(steps.size()), 128'(0));
    check("busy_after_rel", 128'(entry_busy), 128'(1'b0));
    check("rel_vld_after", 128'(rel_vld), 128'(1'b0));
  endtask

  initial begin
    pack_l1d_mshr_req r;
    logic iw_v, et_v, abc_v;
    l1d_mshr_id_t iw_id, et_id, abc_id;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(entry_busy), 128'(1'b0));
    check("rst_vlds", 128'({evict_req_vld, linefill_req_vld, rw_req_vld, rel_vld}), 128'(0));
    check("rst_pld", 128'(rw_req_pld), 128'(0));
    check("rst_rel_id", 128'(rel_id), 128'(TB_ID));
    check("rst_timeout", 128'(timeout_err), 128'(1'b0));

    // Hit with no hazard: minimum latency.
    r = rand_req(); r.need_evict = 1'b0; r.need_linefill = 1'b0;
    run_txn(r, 1'b0, '0, 1'b0, '0, 1'b0, '0, 0, 0);

    // Dirty miss with fixed victim.
    r = rand_req(); r.need_evict = 1'b1; r.need_linefill = 1'b1;
    r.index = 6'd5; r.way = 4'b0100; r.evict_tag = 20'h3A;
    run_txn(r, 1'b0, '0, 1'b0, '0, 1'b0, '0, 0, 0);

    // Index/way hazard on id 3: id 2 broadcasts must not clear it.
    r = rand_req();
    run_txn(r, 1'b1, 3'd3, 1'b0, '0, 1'b0, '0, 1, 0);

    // Release coincides with allocation.
    r = rand_req();
    run_txn(r, 1'b1, 3'd3, 1'b0, '0, 1'b1, 3'd3, 0, 0);

    // Evict ready withheld for 5 cycles.
    r = rand_req(); r.need_evict = 1'b1; r.need_linefill = 1'b1;
    run_txn(r, 1'b0, '0, 1'b0, '0, 1'b0, '0, 0, 2);

    // Both hazards on the same id clear together.
    r = rand_req();
    run_txn(r, 1'b1, 3'd1, 1'b1, 3'd1, 1'b0, '0, 0, 1);

    for (int t = 0; t < 40; t++) begin
      r = rand_req();
      iw_v = 1'($urandom); et_v = 1'($urandom);
      iw_id = rand_peer(); et_id = rand_peer();
      abc_v = ($urandom_range(0, 3) == 0);
      abc_id = $urandom_range(0, 1) ? iw_id : rand_peer();
      run_txn(r, iw_v, iw_id, et_v, et_id, abc_v, abc_id, 0, int'($urandom_range(0, 2)));
    end

    // Reset in LF_WAIT.
    r = rand_req(); r.need_evict = 1'b0; r.need_linefill = 1'b1;
    alloc_vld = 1'b1; alloc_pld = '{req: r, mshr_hzd_index_way_line: '0, mshr_hzd_evict_tag_line: '0};
    linefill_req_rdy = 1'b1;
    @(negedge clk);
    alloc_vld = 1'b0;
    check("rst_mid_lf_req", 128'(linefill_req_vld), 128'(1'b1));
    @(negedge clk);
    linefill_req_rdy = 1'b0;
    check("rst_mid_lf_wait", 128'({entry_busy, linefill_req_vld}), 128'(2'b10));
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 128'(entry_busy), 128'(1'b0));
    check("rst_mid_vlds", 128'({evict_req_vld, linefill_req_vld, rw_req_vld, rel_vld}), 128'(0));
    check("rst_mid_pld", 128'(linefill_req_pld), 128'(0));
    check("rst_mid_rel_id", 128'(rel_id), 128'(TB_ID));
    @(negedge clk);
    rst_n = 1'b1;
    linefill_done = 1'b1;
    @(negedge clk);
    linefill_done = 1'b0;
    check("stray_done_ignored", 128'({entry_busy, rw_req_vld}), 128'(0));

`ifdef L1D_MSHR_TIMEOUT_EN
    // Watchdog: withhold linefill_done.
    r = rand_req(); r.need_evict = 1'b0; r.need_linefill = 1'b1;
    alloc_vld = 1'b1; alloc_pld = '{req: r, mshr_hzd_index_way_line: '0, mshr_hzd_evict_tag_line: '0};
    linefill_req_rdy = 1'b1; rw_req_rdy = 1'b1;
    @(negedge clk);
    alloc_vld = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      check("wdog_rise", 128'(timeout_err), 128'(j >= 16));
      @(negedge clk);
    end
    linefill_done = 1'b1;
    @(negedge clk);
    linefill_done = 1'b0;
    repeat (3) @(negedge clk);
    check("wdog_sticky", 128'({timeout_err, entry_busy}), 128'(2'b10));
    rst_n = 1'b0;
    #1;
    check("wdog_rst", 128'(timeout_err), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/l1d_mshr_entry.md
Name: l1d_mshr_entry

Overview:
- Single MSHR entry that sequences one L1D miss or hit request after tag lookup.
- Accepts the pack_l1d_mshr_state record produced by the tag-behaviour mapping stage.
- Waits out index/way and evict-tag hazards against older entries, then issues evict, linefill and data-array RW requests in order.
- Broadcasts its own release when done. An array of L1D_MSHR_NUM instances forms the MSHR file.

Parameters:
- ENTRY_ID, 0, this entry's MSHR id. Compared against broadcast release ids; driven on rel_id.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with L1D_MSHR_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_vld  in  1  allocate this entry this cycle
- alloc_pld  in  pack_l1d_mshr_state  request record (index, new_tag, evict_tag, offset, need_rw, wr_data, wr_data_byte_en, wr_sb_pld, need_evict, need_linefill, way, hazard ids, mshr_id)
- alloc_hzd_iw_vld  in  1  mshr_hzd_index_way_line field is a live dependency
- alloc_hzd_et_vld  in  1  mshr_hzd_evict_tag_line field is a live dependency
- rel_bcast_vld  in  1  some entry releases this cycle
- rel_bcast_id  in  L1D_MSHR_ID_WIDTH  id of releasing entry
- entry_busy  out  1  entry not IDLE
- evict_req_vld  out  1  / evict_req_rdy  in  1  / evict_req_pld  out  pack_l1d_evict_req  (index, way, evict_tag)
- evict_done  in  1  victim data read out of data array
- linefill_req_vld  out  1  / linefill_req_rdy  in  1  / linefill_req_pld  out  pack_l1d_linefill_req  (new_tag, index, way, mshr_id)
- linefill_done  in  1  refill data written to data array
- rw_req_vld  out  1  / rw_req_rdy  in  1  / rw_req_pld  out  pack_l1d_rw_req  (index, way, offset, is_read=need_rw, wr_data, byte_en, sb_pld, mshr_id)
- rel_vld  out  1  one-cycle release pulse
- rel_id  out  L1D_MSHR_ID_WIDTH  constant ENTRY_ID
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE. All outputs 0 except rel_id = ENTRY_ID. Payload registers cleared. Hazard flags cleared. Watchdog cleared.
- States: IDLE, WAIT_HZD, EVICT_REQ, EVICT_WAIT, LF_REQ, LF_WAIT, RW_REQ, RELEASE.
- IDLE + alloc_vld:
  - Latch alloc_pld.
  - hzd_iw = alloc_hzd_iw_vld && !(rel_bcast_vld && rel_bcast_id == hzd_index_way_line).
  - hzd_et is computed the same way.
  - A release seen in the allocation cycle therefore clears the dependency.
  - Next state: WAIT_HZD if any flag is set; else EVICT_REQ if need_evict; else LF_REQ if need_linefill; else RW_REQ.
- alloc_vld while not IDLE: ignored; state and payload unchanged (bench asserts this never occurs).
- WAIT_HZD: each flag clears on a matching broadcast. Once both flags are 0, advance the next cycle to the dispatch target using the IDLE rules. Both flags clearing in the same cycle is legal.
- EVICT_REQ: evict_req_vld=1 and payload stable until evict_req_rdy. vld&&rdy -> EVICT_WAIT.
- EVICT_WAIT: on evict_done -> LF_REQ. need_evict implies need_linefill.
- LF_REQ: linefill_req_vld held until rdy -> LF_WAIT. LF_WAIT: on linefill_done -> RW_REQ.
- RW_REQ: rw_req_vld held until rdy -> RELEASE.
- RELEASE: rel_vld=1 for exactly 1 cycle -> IDLE. entry_busy drops the cycle after RELEASE.
- Done strobes (evict_done, linefill_done) arriving outside their wait state are ignored.
- Minimum latency for a hit with no hazard: alloc at cycle 0, rw_req_vld at cycle 1, rel_vld at cycle 2 (with rdy held high).
- Broadcasts carrying this entry's own ENTRY_ID never clear its own flags. This holds by construction: the entry is busy and not releasing.
- rst_n asserted mid-operation returns to IDLE immediately. Pending requests drop without a handshake.

Optional Feature:
- L1D_MSHR_TIMEOUT_EN defined:
  - 16-bit counter resets on every state change.
  - Counter increments in WAIT_HZD, EVICT_WAIT and LF_WAIT.
  - Reaching TIMEOUT_CYCLES sets timeout_err, which stays sticky until reset. The FSM is unaffected.
- Undefined: counter absent; timeout_err tied 0.

Decomposition:
- l1d_package gains:
  - pack_l1d_evict_req, pack_l1d_linefill_req, pack_l1d_rw_req
  - enum l1d_mshr_fsm_e
  - L1D_MSHR_NUM (L1D_MSHR_ID_WIDTH derives from it)
- One sub-module: l1d_mshr_hzd_tracker. It holds the two hazard flags plus the captured ids, does the release-match/clear logic and outputs hzd_pending.

Test Plan:
- Hit, need_evict=0, need_linefill=0, no hazards, all rdy=1, alloc at cycle 0 -> rw_req_vld cycle 1 with way from alloc_pld; rel_vld cycle 2; entry_busy low cycle 3.
- Dirty miss (need_evict=1, index=5, way=4'b0100, evict_tag=0x3A) -> evict_req_pld = {5, 0100, 0x3A}. After evict_done -> linefill_req_pld.new_tag = alloc new_tag. After linefill_done -> rw_req. Order is strictly evict, linefill, rw.
- hzd_iw on id 3, no release for 10 cycles -> no request asserted. rel_bcast id 3 -> first request on the next cycle. A broadcast of id 2 has no effect.
- Allocation coinciding with rel_bcast_vld for its only hazard id -> no WAIT_HZD entry; request the next cycle.
- evict_req_rdy held 0 for 5 cycles -> vld and payload stable throughout. rst_n low mid-LF_WAIT -> all outputs 0, state IDLE.
- With L1D_MSHR_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold linefill_done -> timeout_err rises after 16 cycles in LF_WAIT and stays set after linefill_done.
